ram_lsu_port: RTL and testbench

- Initiator-side load/store unit that drives one port of the team's dual-port synchronous word RAM.
- The RAM port is 32-bit word-addressed, has no byte enables and a one-cycle read latency.
- Converts core byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word reads, sign/zero extension, and read-modify-write sequences.
- Sits between the core execute/memory stage and RAM port B.

---
 rtl/ram_lsu_port.sv | 160 ++++++++++++++++
 tb/tb_ram_lsu_port.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu_port.sv
// Byte-addressed load/store front end for one port of a word-wide, 1-cycle-latency RAM.
// Optional build macro LSU_MISALIGN_CHECK_EN enables misaligned/reserved-size error responses.
module ram_lsu_port #(
    parameter int DEPTH      = 2**16,
    parameter int ADDR_WIDTH = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [AW-1:0]         o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_mem_we,
    input  logic [31:0]           i_mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RSP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_we;
    logic            r_uns;
    logic [1:0]      r_size;
    logic [1:0]      r_off;
    logic [31:0]     r_wdata;
    logic [31:0]     r_word;
    logic [31:0]     r_rdata;
    logic [AW-1:0]   r_mem_addr;
    logic            w_accept;
    logic            w_mis;
    logic [1:0]      w_size_n;
    logic [1:0]      w_off_n;
    logic            w_unused_addr_bits;

    // Address bits above the RAM word range wrap and are intentionally dropped.
    assign w_unused_addr_bits = ^i_req_addr[ADDR_WIDTH-1:AW+2];
    assign w_accept = i_req_valid && (r_state == S_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_err;
    assign w_size_n = i_req_size;
    assign w_off_n  = i_req_addr[1:0];
    assign w_mis    = (i_req_size == 2'b11) ||
                      ((i_req_size == 2'b01) && i_req_addr[0]) ||
                      ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
    assign o_rsp_err = (r_state == S_RSP) && r_err;
`else
    // Without checking, reserved size behaves as word and low address bits snap to alignment.
    assign w_size_n = (i_req_size == 2'b11) ? 2'b10 : i_req_size;
    assign w_off_n  = (w_size_n == 2'b10) ? 2'b00 :
                      (w_size_n == 2'b01) ? {i_req_addr[1], 1'b0} : i_req_addr[1:0];
    assign w_mis    = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    function automatic logic [31:0] f_load_ext(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   f_load_ext = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   f_load_ext = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: f_load_ext = sh;
        endcase
    endfunction

    function automatic logic [31:0] f_store_merge(input logic [31:0] rdata, input logic [31:0] wdata,
                                                  input logic [1:0] size, input logic [1:0] off);
        logic [31:0] w;
        w = rdata;
        case (size)
            2'b00:   w[{off, 3'b000} +: 8]        = wdata[7:0];
            2'b01:   w[{off[1], 4'b0000} +: 16]   = wdata[15:0];
            default: w                            = wdata;
        endcase
        f_store_merge = w;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_mis)
                        w_state_nxt = S_RSP;
                    else if (i_req_we && (w_size_n == 2'b10))
                        w_state_nxt = S_WR;
                    else
                        w_state_nxt = S_RD;
                end
            end
            S_RD:    w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = r_we ? S_WR : S_RSP;
            S_WR:    w_state_nxt = S_RSP;
            S_RSP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_word doubles as the full-word store payload and the read-modify-write merge result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'b00;
            r_off      <= 2'b00;
            r_wdata    <= 32'h0;
            r_word     <= 32'h0;
            r_rdata    <= 32'h0;
            r_mem_addr <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_we    <= i_req_we;
            r_uns   <= i_req_unsigned;
            r_size  <= w_size_n;
            r_off   <= w_off_n;
            r_wdata <= i_req_wdata;
            r_rdata <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err   <= w_mis;
`endif
            if (!w_mis)
                r_mem_addr <= i_req_addr[AW+1:2];
            if (i_req_we && (w_size_n == 2'b10))
                r_word <= i_req_wdata;
        end else if (r_state == S_CAP) begin
            if (r_we)
                r_word <= f_store_merge(i_mem_rdata, r_wdata, r_size, r_off);
            else
                r_rdata <= f_load_ext(i_mem_rdata, r_size, r_off, r_uns);
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RSP);
    assign o_mem_we    = (r_state == S_WR);
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_word;
    assign o_rsp_rdata = r_rdata;

endmodule

// File: tb/tb_ram_lsu_port.sv
// Directed bench for ram_lsu_port with a behavioural 1-cycle-latency word RAM on port B.
module tb_ram_lsu_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [31:0] mem [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [31:0] pre_data = 32'h0;

    always #5 clk = ~clk;

    ram_lsu_port dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_addr     (req_addr),
        .i_req_size     (req_size),
        .i_req_unsigned (req_uns),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_we       (mem_we),
        .i_mem_rdata    (mem_rdata)
    );

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (mem_we)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we)
            we_cnt <= we_cnt + 1;
    end

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Presents one request for one edge; returns 1 time unit after the accept edge T.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_uns = uns; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_size = 2'b00; req_uns = 1'b0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_err, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {rsp_valid, rsp_err, mem_we}); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata); end
        checks++; if ({mem_addr, mem_wdata} !== 48'h0) begin errors++; $display("FAIL reset_mem_out: got %h/%h expected 0/0", mem_addr, mem_wdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        preload(16'h0010, 32'h8899AABB);
    endtask

    task automatic test_loads();
        logic [31:0] addrs [6] = '{32'h41, 32'h41, 32'h42, 32'h42, 32'h40, 32'h43};
        logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
        logic        unss  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exps  [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'h00008899, 32'hFFFF8899,
                                   32'h8899AABB, 32'hFFFFFF88};
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, addrs[i], sizes[i], unss[i], 32'hFFFFFFFF);
            checks++; if ({req_ready, mem_we, mem_addr} !== {2'b00, 16'h0010}) begin errors++; $display("FAIL load%0d_rd: got rdy=%b we=%b addr=%h expected 0 0 0010", i, req_ready, mem_we, mem_addr); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load%0d_early: got valid=%b expected 0", i, rsp_valid); end
            @(posedge clk); #1;
            checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, exps[i]}) begin errors++; $display("FAIL load%0d_rsp: got v=%b e=%b d=%h expected 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, exps[i]); end
            @(posedge clk); #1;
            checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL load%0d_end: got v=%b rdy=%b expected 0 1", i, rsp_valid, req_ready); end
        end
    endtask

    task automatic test_misalign();
        int c0;
        c0 = we_cnt;
        issue(1'b0, 32'h41, 2'b10, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL misalign_rsp: got v=%b e=%b d=%h expected 1 1 00000000", rsp_valid, rsp_err, rsp_rdata); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (we_cnt !== c0) begin errors++; $display("FAIL misalign_nowrite: got %0d writes expected 0", we_cnt - c0); end
`else
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL misalign_addr: got %h expected 0010", mem_addr); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h8899AABB}) begin errors++; $display("FAIL misalign_rsp: got v=%b e=%b d=%h expected 1 0 8899aabb", rsp_valid, rsp_err, rsp_rdata); end
        @(posedge clk); #1;
        checks++; if (we_cnt !== c0) begin errors++; $display("FAIL misalign_nowrite: got %0d writes expected 0", we_cnt - c0); end
`endif
    endtask

    task automatic test_reset_abort();
        int c0;
        c0 = we_cnt;
        issue(1'b1, 32'h40, 2'b01, 1'b0, 32'h0000CAFE);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, rsp_err, mem_we} !== 3'b000) begin errors++; $display("FAIL abort_ctrl: got %b expected 000", {rsp_valid, rsp_err, mem_we}); end
        checks++; if ({mem_addr, mem_wdata, rsp_rdata} !== 80'h0) begin errors++; $display("FAIL abort_data: got %h/%h/%h expected 0/0/0", mem_addr, mem_wdata, rsp_rdata); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", req_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (we_cnt !== c0) begin errors++; $display("FAIL abort_nowrite: got %0d writes expected 0", we_cnt - c0); end
        checks++; if (mem[16] !== 32'h8899AABB) begin errors++; $display("FAIL abort_mem: got %h expected 8899aabb", mem[16]); end
    endtask

    task automatic test_store_byte();
        int c0;
        c0 = we_cnt;
        issue(1'b1, 32'h43, 2'b00, 1'b0, 32'h12345611);
        checks++; if ({req_ready, mem_we, mem_addr} !== {2'b00, 16'h0010}) begin errors++; $display("FAIL sb_rd: got rdy=%b we=%b addr=%h expected 0 0 0010", req_ready, mem_we, mem_addr); end
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sb_cap_we: got %b expected 0", mem_we); end
        @(posedge clk); #1;
        checks++; if ({mem_we, mem_addr, mem_wdata, rsp_valid} !== {1'b1, 16'h0010, 32'h1199AABB, 1'b0}) begin errors++; $display("FAIL sb_wr: got we=%b addr=%h data=%h v=%b expected 1 0010 1199aabb 0", mem_we, mem_addr, mem_wdata, rsp_valid); end
        @(posedge clk); #1;
        checks++; if ({rsp_valid, rsp_err, mem_we, rsp_rdata} !== {3'b100, 32'h0}) begin errors++; $display("FAIL sb_rsp: got v=%b e=%b we=%b d=%h expected 1 0 0 00000000", rsp_valid, rsp_err, mem_we, rsp_rdata); end
        checks++; if (we_cnt !== c0 + 1) begin errors++; $display("FAIL sb_wcount: got %0d writes expected 1", we_cnt - c0); end
        issue(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h1199AABB}) begin errors++; $display("FAIL sb_readback: got v=%b d=%h expected 1 1199aabb", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_store_word();
        issue(1'b1, 32'h44, 2'b10, 1'b0, 32'hDEADBEEF);
        checks++; if ({req_ready, mem_we, mem_addr, mem_wdata} !== {2'b01, 16'h0011, 32'hDEADBEEF}) begin errors++; $display("FAIL sw_wr: got rdy=%b we=%b addr=%h data=%h expected 0 1 0011 deadbeef", req_ready, mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        checks++; if ({req_ready, mem_we, rsp_valid, rsp_err} !== 4'b0010) begin errors++; $display("FAIL sw_rsp: got rdy=%b we=%b v=%b e=%b expected 0 0 1 0", req_ready, mem_we, rsp_valid, rsp_err); end
        @(posedge clk); #1;
        checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL sw_idle: got rdy=%b v=%b expected 1 0", req_ready, rsp_valid); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44; req_size = 2'b10; req_uns = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if ({req_ready, mem_we, mem_addr} !== {2'b00, 16'h0011}) begin errors++; $display("FAIL sw_reaccept: got rdy=%b we=%b addr=%h expected 0 0 0011", req_ready, mem_we, mem_addr); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL sw_readback: got v=%b d=%h expected 1 deadbeef", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int rsp [$];
        logic prev_rsp;
        int dbl;
        prev_rsp = 1'b0;
        dbl = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'b10; req_uns = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            logic acc_now;
            acc_now = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                acc.push_back(c);
                if (acc.size() == 3)
                    req_valid = 1'b0;
            end
            if (rsp_valid) begin
                rsp.push_back(c);
                checks++; if (rsp_rdata !== 32'h1199AABB) begin errors++; $display("FAIL b2b_data: got %h expected 1199aabb", rsp_rdata); end
                if (prev_rsp)
                    dbl++;
            end
            prev_rsp = rsp_valid;
        end
        checks++; if (acc.size() !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc.size()); end
        checks++; if (rsp.size() !== 3) begin errors++; $display("FAIL b2b_rsps: got %0d expected 3", rsp.size()); end
        checks++; if (dbl !== 0) begin errors++; $display("FAIL b2b_pulse: got %0d wide pulses expected 0", dbl); end
        if (acc.size() == 3 && rsp.size() == 3) begin
            checks++; if ({acc[1] - acc[0], acc[2] - acc[1]} !== {32'd4, 32'd4}) begin errors++; $display("FAIL b2b_acc_gap: got %0d,%0d expected 4,4", acc[1] - acc[0], acc[2] - acc[1]); end
            checks++; if ({rsp[1] - rsp[0], rsp[2] - rsp[1]} !== {32'd4, 32'd4}) begin errors++; $display("FAIL b2b_rsp_gap: got %0d,%0d expected 4,4", rsp[1] - rsp[0], rsp[2] - rsp[1]); end
            checks++; if (rsp[0] - acc[0] !== 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", rsp[0] - acc[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_misalign();
        test_reset_abort();
        test_store_byte();
        test_store_word();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
